// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter that shares one 4:1 data mux between four
//               valid/ready producer streams. The grant is held for a whole
//               packet (until an accepted beat with last=1). The muxed beat is
//               registered into a one-entry output stage that can drain and
//               refill in the same cycle. The registered select code is
//               exported so sibling mux trees can steer in step with it.
// Ports       : clk_i        - clock, rising edge
//               rst_ni       - asynchronous active-low reset
//               in_valid_i   - per-requester beat valid [3:0]
//               in_ready_o   - per-requester beat accept [3:0]
//               in_data_i    - requester k data in [k*WIDTH +: WIDTH]
//               in_last_i    - per-requester end-of-packet flag [3:0]
//               out_valid_o  - output register holds a beat
//               out_ready_i  - consumer accepts the beat
//               out_data_o   - registered muxed data
//               out_last_o   - registered last flag
//               sel_o        - source index of most recently accepted beat
//               busy_o       - arbiter locked mid-packet
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [3:0]           in_valid_i,
    output logic [3:0]           in_ready_o,
    input  logic [4*WIDTH-1:0]   in_data_i,
    input  logic [3:0]           in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_last_o,
    output logic [1:0]           sel_o,
    output logic                 busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_ptr_nxt;
    logic [1:0]         r_sel;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_last;

    logic [1:0]         w_grant;
    logic               w_grant_vld;
    logic               w_space;
    logic [3:0]         w_in_ready;
    logic [1:0]         w_src;
    logic               w_accept;
    logic               w_src_last;
    logic [WIDTH-1:0]   w_src_data;

    // The output stage can take a new beat when empty or when it is being
    // drained this very cycle.
    assign w_space = ~r_out_valid | out_ready_i;

    // Rotating priority search starting at r_ptr. Iterating from the farthest
    // offset down to zero lets the nearest valid requester win.
    always_comb begin
        w_grant     = r_ptr;
        w_grant_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (in_valid_i[r_ptr + 2'(i)]) begin
                w_grant     = r_ptr + 2'(i);
                w_grant_vld = 1'b1;
            end
        end
    end

    // Next-state / output logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_src       = w_grant;
        w_in_ready  = 4'b0000;

        case (r_state)
            ST_IDLE: begin
                w_src = w_grant;
                if (w_grant_vld) begin
                    w_in_ready[w_grant] = w_space;
                end
            end
            ST_LOCKED: begin
                // Owner keeps the grant even while it bubbles.
                w_src             = r_sel;
                w_in_ready[r_sel] = w_space;
            end
            default: begin
                w_src = w_grant;
            end
        endcase

        w_accept   = |(in_valid_i & w_in_ready);
        w_src_last = in_last_i[w_src];

        if (w_accept) begin
            if (w_src_last) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = w_src + 2'd1;
            end else begin
                w_state_nxt = ST_LOCKED;
            end
        end
    end

    assign w_src_data = in_data_i[int'(w_src)*WIDTH +: WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // One-entry output register; data is deliberately left in place when the
    // stage empties.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_sel       <= 2'd0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_src_data;
            r_out_last  <= w_src_last;
            r_sel       <= w_src;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign sel_o       = r_sel;
    assign busy_o      = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Self-checking bench for mux4_rr_arbiter. Directed scenarios
//               plus a randomized phase, all checked every cycle against a
//               packet-level reference model of the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int WIDTH = 8;

    logic                clk_i;
    logic                rst_ni;
    logic [3:0]          in_valid_i;
    logic [3:0]          in_ready_o;
    logic [4*WIDTH-1:0]  in_data_i;
    logic [3:0]          in_last_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [WIDTH-1:0]    out_data_o;
    logic                out_last_o;
    logic [1:0]          sel_o;
    logic                busy_o;

    mux4_rr_arbiter #(.WIDTH(WIDTH)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .sel_o       (sel_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet owner, rotating start point, output register.
    int               m_ptr;
    int               m_owner;
    bit               m_lock;
    bit               m_ov;
    bit               m_last;
    int               m_sel;
    logic [WIDTH-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = 0;
        m_lock  = 0;
        m_ov    = 0;
        m_last  = 0;
        m_sel   = 0;
        m_data  = '0;
    endtask

    task automatic chk_regs();
        chk("out_valid", 32'(out_valid_o), 32'(m_ov));
        chk("out_data",  32'(out_data_o),  32'(m_data));
        chk("out_last",  32'(out_last_o),  32'(m_last));
        chk("sel",       32'(sel_o),       32'(m_sel));
        chk("busy",      32'(busy_o),      32'(m_lock));
    endtask

    // One cycle: check registered state, apply inputs, check the combinational
    // ready vector, advance the model, then move to the next falling edge.
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rdy);
        int   k;
        bit   found;
        bit   space;
        bit   acc;
        logic [3:0] exp_rdy;
        chk_regs();
        in_valid_i  = v;
        in_last_i   = l;
        out_ready_i = rdy;
        for (int d = 0; d < 4; d++) in_data_i[d*WIDTH +: WIDTH] = WIDTH'($urandom);
        #1;
        space = !m_ov || rdy;
        found = 0;
        k     = 0;
        if (m_lock) begin
            k     = m_owner;
            found = 1;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (!found && v[(m_ptr + j) % 4]) begin
                    k     = (m_ptr + j) % 4;
                    found = 1;
                end
            end
        end
        exp_rdy = (found && space) ? (4'b0001 << k) : 4'b0000;
        chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
        acc = found && space && v[k];
        if (acc) begin
            m_ov   = 1;
            m_data = in_data_i[k*WIDTH +: WIDTH];
            m_last = l[k];
            m_sel  = k;
            if (l[k]) begin
                m_lock = 0;
                m_ptr  = (k + 1) % 4;
            end else begin
                m_lock  = 1;
                m_owner = k;
            end
        end else if (rdy) begin
            m_ov = 0;
        end
        @(negedge clk_i);
    endtask

    initial begin
        model_reset();
        rst_ni      = 1'b0;
        in_valid_i  = 4'b0;
        in_last_i   = 4'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_regs();
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        rst_ni = 1'b1;

        // Idle after reset
        repeat (5) drive(4'b0000, 4'b0000, 1'b1);

        // Fairness: every requester valid, single-beat packets -> 0,1,2,3,0,1
        repeat (6) drive(4'b1111, 4'b1111, 1'b1);

        // Packet lock: ptr now 2; requester 2 sends 3 beats while 0 and 3 wait
        drive(4'b1101, 4'b0000, 1'b1);
        drive(4'b1101, 4'b0000, 1'b1);
        drive(4'b1101, 4'b0100, 1'b1);
        drive(4'b1001, 4'b1001, 1'b1);   // requester 3 next
        drive(4'b1001, 4'b1001, 1'b1);   // then requester 0
        drive(4'b0000, 4'b0000, 1'b1);

        // Backpressure: register full, consumer stalls, then resumes
        drive(4'b0110, 4'b0110, 1'b0);
        repeat (3) drive(4'b0110, 4'b0110, 1'b0);
        repeat (3) drive(4'b0110, 4'b0110, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Bubble inside a lock held by requester 1
        drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b1101, 4'b1101, 1'b1);
        drive(4'b1101, 4'b1101, 1'b1);
        drive(4'b1111, 4'b1111, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            drive(4'($urandom), 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        drive(4'b0000, 4'b1111, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Reset mid-packet from requester 1 (beat 2 of 4 in flight)
        drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b0010, 4'b0000, 1'b1);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_sel",       32'(sel_o),       32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(4'b0011, 4'b0011, 1'b1);   // requester 0 wins first
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
